seq_controller: RTL and testbench
=================================

SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 The block SHALL have one parameter: STICKY_HALT, default 1. When 1, HLT freezes sequencing until a cont pulse. When 0, halt is a single phase-4 pulse and sequencing continues.
REQ-002 The block SHALL have the following ports, one per line:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  3  instruction-register opcode field. Encoding: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- is_zero  input  1  ALU zero flag (accumulator == 0)
- cont  input  1  resume request while halted
- sel  output  1  address mux selects PC (1) or IR operand (0)
- rd  output  1  memory read enable
- ld_ir  output  1  instruction-register load
- inc_pc  output  1  program-counter increment
- ld_pc  output  1  program-counter load (jump)
- data_e  output  1  accumulator drives data bus
- ld_ac  output  1  accumulator load from ALU res
- wr  output  1  memory write strobe
- halt  output  1  processor halted / halt pulse
- phase  output  3  current phase, for debug
REQ-003 The block SHALL have exactly one clock and one reset: clk, and rst_n, which is asynchronous and active-low.

Function
REQ-004 The block SHALL sequence each instruction through 8 phases, held in a 3-bit register: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-005 The phase register SHALL advance by 1 per clock, with 7 wrapping to 0, except as stated in REQ-011 to REQ-013.
REQ-006 ALUOP SHALL be defined as opcode in {ADD, AND, XOR, LDA}.
REQ-007 Outputs SHALL be a combinational decode of the phase register, opcode, is_zero and the halt state. Any output not listed for a phase SHALL be 0.
REQ-008 Phases 0 to 3 SHALL drive the following:
- Phase 0: sel=1.
- Phase 1: sel=1, rd=1.
- Phases 2 and 3: sel=1, rd=1, ld_ir=1.
REQ-009 Phases 4 to 7 SHALL drive the following:
- Phase 4: inc_pc=1; halt=1 if opcode==HLT.
- Phase 5: rd=ALUOP.
- Phase 6: rd=ALUOP; inc_pc=(opcode==SKZ && is_zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
- Phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); data_e=(opcode==STO); wr=(opcode==STO).
REQ-010 The opcode input SHALL be used only in phases 4 to 7. In phases 0 to 3 it SHALL have no effect on any output.
REQ-011 With STICKY_HALT=1, on the clock edge that ends phase 4 with opcode==HLT, the block SHALL enter a HALTED state: the phase register holds at 4, halt=1, and all other outputs are 0.
REQ-012 In HALTED with cont=1 at a rising edge, the block SHALL exit HALTED and the phase register SHALL go to 5. The instruction then completes as a no-op: phases 5 to 7 drive all outputs 0 for HLT.
REQ-013 A cont of 1 outside HALTED SHALL be ignored. A cont held high SHALL resume only once, because HLT is re-detected only in a later phase 4.
REQ-014 With STICKY_HALT=0, HLT SHALL produce halt=1 for exactly one cycle (phase 4), and sequencing SHALL continue uninterrupted.
REQ-015 is_zero SHALL be sampled combinationally during phase 6 only; its value in any other phase SHALL be ignored.
REQ-016 At most one of inc_pc and ld_pc SHALL be 1 in any cycle, and wr=1 SHALL imply data_e=1.

Reset
REQ-017 While rst_n=0, the block SHALL set phase=0 and clear HALTED, independent of clk.
REQ-018 During reset, outputs SHALL reflect phase 0: sel=1 and all other outputs 0.
REQ-019 Reset asserted mid-instruction or in HALTED SHALL abort the instruction. The first rising edge after rst_n deasserts SHALL move the phase to 1.

Verification
REQ-020 Reset then 8 clocks with opcode=ADD SHALL yield phase 0 to 7 to 0, and rd=1 in phases 1, 2, 3, 5, 6 and 7. ld_ac=1 SHALL occur only in phase 7, and inc_pc=1 only in phase 4.
REQ-021 opcode=SKZ SHALL give inc_pc=1 in phase 6 when is_zero=1, and inc_pc=0 in phase 6 when is_zero=0. Phase 4 inc_pc=1 SHALL hold in both cases.
REQ-022 opcode=STO SHALL give data_e=1 in phases 6 and 7, wr=1 only in phase 7, and rd=0 in phases 5 to 7.
REQ-023 opcode=JMP SHALL give ld_pc=1 in phases 6 and 7, and inc_pc=0 in phase 6.
REQ-024 With STICKY_HALT=1 and opcode=HLT, the bench SHALL check:
- Phase SHALL hold at 4 with halt=1 for 20 cycles.
- A 1-cycle cont pulse SHALL move the phase to 5, then 6, 7, 0.
- All outputs SHALL be 0 in phases 5 to 7.
REQ-025 Asserting rst_n=0 asynchronously in phase 6 and in HALTED SHALL immediately give phase=0, sel=1 and halt=0. After release, sequencing SHALL restart from phase 0.

Source files
------------

// File: rtl/seq_controller.sv
// Instruction sequencer for a simple accumulator CPU.
// Walks every instruction through eight phases and decodes the datapath
// control strobes from the current phase, opcode and ALU zero flag.
// With STICKY_HALT=1 an HLT instruction parks the sequencer in phase 4
// until cont is pulsed; with STICKY_HALT=0 halt is a one-phase pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   opcode   in   [2:0] IR opcode field (HLT..JMP)
//   is_zero  in   accumulator == 0
//   cont     in   resume request while halted
//   sel      out  address mux: 1 = PC, 0 = IR operand
//   rd       out  memory read enable
//   ld_ir    out  instruction register load
//   inc_pc   out  program counter increment
//   ld_pc    out  program counter load (jump)
//   data_e   out  accumulator drives data bus
//   ld_ac    out  accumulator load from ALU result
//   wr       out  memory write strobe
//   halt     out  halted / halt pulse
//   phase    out  [2:0] current phase, debug
module seq_controller #(
    parameter bit STICKY_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       is_zero,
    input  logic       cont,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next phase: free-running wrap, parked in phase 4 while halted
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q) begin
            if (cont) begin
                halted_d = 1'b0;
                phase_d  = PH_OP_FETCH;
            end
        end else if (STICKY_HALT && phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
            halted_d = 1'b1;
        end else begin
            phase_d = phase_e'(3'(phase_q) + 3'd1);
        end
    end

    assign aluop_c = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);

    // Control decode; opcode only matters in the operand half (phases 4-7)
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = aluop_c;
                end
                PH_ALU_OP: begin
                    rd     = aluop_c;
                    inc_pc = (opcode == OP_SKZ) && is_zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    rd     = aluop_c;
                    ld_ac  = aluop_c;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    wr     = (opcode == OP_STO);
                end
            endcase
        end
    end

    assign phase = 3'(phase_q);

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: one sticky-halt and one pulse-halt
// instance share all inputs and are compared against a phase-level model.
module tb_seq_controller;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       is_zero = 1'b0;
    logic       cont = 1'b0;

    // {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt}
    wire [8:0] o1, o0;
    wire [2:0] ph1, ph0;

    int n_vec = 0;
    int n_err = 0;
    int m_ph[2];
    bit m_hl[2];

    always #5 clk = ~clk;

    seq_controller #(.STICKY_HALT(1'b1)) dut_sticky (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .is_zero(is_zero), .cont(cont),
        .sel(o1[8]), .rd(o1[7]), .ld_ir(o1[6]), .inc_pc(o1[5]), .ld_pc(o1[4]),
        .data_e(o1[3]), .ld_ac(o1[2]), .wr(o1[1]), .halt(o1[0]), .phase(ph1)
    );

    seq_controller #(.STICKY_HALT(1'b0)) dut_pulse (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .is_zero(is_zero), .cont(cont),
        .sel(o0[8]), .rd(o0[7]), .ld_ir(o0[6]), .inc_pc(o0[5]), .ld_pc(o0[4]),
        .data_e(o0[3]), .ld_ac(o0[2]), .wr(o0[1]), .halt(o0[0]), .phase(ph0)
    );

    // Expected strobes for a phase number, written from the phase table
    function automatic logic [8:0] exp_out(input int ph, input bit hl,
                                           input logic [2:0] op, input logic z);
        logic [8:0] v;
        logic alu;
        v   = '0;
        alu = op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
        if (hl) begin
            v[0] = 1'b1;
            return v;
        end
        v[8] = (ph < 4);
        v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        v[6] = (ph == 2 || ph == 3);
        v[5] = (ph == 4) || (ph == 6 && op == OP_SKZ && z);
        v[4] = (ph >= 6) && (op == OP_JMP);
        v[3] = (ph >= 6) && (op == OP_STO);
        v[2] = (ph == 7) && alu;
        v[1] = (ph == 7) && (op == OP_STO);
        v[0] = (ph == 4) && (op == OP_HLT);
        return v;
    endfunction

    task automatic model_reset();
        m_ph[0] = 0; m_ph[1] = 0;
        m_hl[0] = 1'b0; m_hl[1] = 1'b0;
    endtask

    // Called at a negedge: apply inputs and let the decode settle
    task automatic set_in(input logic [2:0] op, input logic z, input logic c);
        opcode  = op;
        is_zero = z;
        cont    = c;
        #1;
    endtask

    // Advance one clock; model follows the phase rules, returns at negedge
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (m_hl[k]) begin
                    if (cont) begin
                        m_hl[k] = 1'b0;
                        m_ph[k] = 5;
                    end
                end else if (k == 1 && m_ph[k] == 4 && opcode == OP_HLT) begin
                    m_hl[k] = 1'b1;
                end else begin
                    m_ph[k] = (m_ph[k] + 1) % 8;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (ph1 !== 3'd0 || o1 !== 9'h100 || ph0 !== 3'd0 || o0 !== 9'h100) begin
            n_err++;
            $display("FAIL reset_state: phase=%0d/%0d out=%b/%b required 0 100000000", ph1, ph0, o1, o0);
        end
        @(negedge clk);
        set_in(OP_JMP, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (ph1 !== 3'd0 || o1 !== 9'h100 || ph0 !== 3'd0 || o0 !== 9'h100) begin
            n_err++;
            $display("FAIL reset_hold: phase=%0d/%0d out=%b/%b required 0 100000000", ph1, ph0, o1, o0);
        end
        rst_n = 1'b1;
        set_in(OP_ADD, 1'b0, 1'b0);
        tick();
        n_vec++;
        if (ph1 !== 3'd1 || ph0 !== 3'd1) begin
            n_err++;
            $display("FAIL reset_release: phase=%0d/%0d required 1", ph1, ph0);
        end
    endtask

    task automatic test_add();
        logic [8:0] e;
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            set_in(OP_ADD, 1'($urandom), 1'b0);
            e = exp_out(m_ph[1], m_hl[1], opcode, is_zero);
            n_vec++;
            if (ph1 !== 3'(i % 8) || o1 !== e) begin
                n_err++;
                $display("FAIL add_seq: cyc=%0d phase=%0d out=%b required phase=%0d out=%b", i, ph1, o1, i % 8, e);
            end
            n_vec++;
            if (o1[7] !== 1'((i % 8) inside {1, 2, 3, 5, 6, 7}) || o1[2] !== 1'(i == 7) ||
                o1[5] !== 1'(i % 8 == 4)) begin
                n_err++;
                $display("FAIL add_strobes: cyc=%0d rd=%b ld_ac=%b inc_pc=%b", i, o1[7], o1[2], o1[5]);
            end
            tick();
        end
    endtask

    task automatic test_skz();
        logic z;
        for (int pass = 0; pass < 2; pass++) begin
            z = (pass == 0);
            do_reset();
            for (int i = 0; i < 8; i++) begin
                set_in(OP_SKZ, (i == 6) ? z : 1'($urandom), 1'b0);
                n_vec++;
                if (o1 !== exp_out(m_ph[1], m_hl[1], opcode, is_zero) ||
                    (i == 6 && o1[5] !== z) || (i == 4 && o1[5] !== 1'b1)) begin
                    n_err++;
                    $display("FAIL skz: z=%b cyc=%0d out=%b required %b", z, i, o1,
                             exp_out(m_ph[1], m_hl[1], opcode, is_zero));
                end
                tick();
            end
        end
    endtask

    task automatic test_sto();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(OP_STO, 1'($urandom), 1'b0);
            n_vec++;
            if (o1[3] !== 1'(i == 6 || i == 7) || o1[1] !== 1'(i == 7) ||
                (i >= 5 && o1[7] !== 1'b0) || o1 !== exp_out(m_ph[1], m_hl[1], opcode, is_zero)) begin
                n_err++;
                $display("FAIL sto: cyc=%0d out=%b required %b", i, o1,
                         exp_out(m_ph[1], m_hl[1], opcode, is_zero));
            end
            tick();
        end
    endtask

    task automatic test_jmp();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(OP_JMP, 1'b1, 1'b0);
            n_vec++;
            if (o1[4] !== 1'(i == 6 || i == 7) || (i == 6 && o1[5] !== 1'b0) ||
                o1 !== exp_out(m_ph[1], m_hl[1], opcode, is_zero)) begin
                n_err++;
                $display("FAIL jmp: cyc=%0d out=%b required %b", i, o1,
                         exp_out(m_ph[1], m_hl[1], opcode, is_zero));
            end
            tick();
        end
    endtask

    task automatic test_halt();
        logic [8:0] e0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(OP_HLT, 1'($urandom), 1'b0);
            n_vec++;
            if (o1 !== exp_out(m_ph[1], m_hl[1], opcode, is_zero) ||
                (i == 4 && (o1[0] !== 1'b1 || o1[5] !== 1'b1 || o0[0] !== 1'b1))) begin
                n_err++;
                $display("FAIL halt_entry: cyc=%0d out=%b pulse_out=%b", i, o1, o0);
            end
            tick();
        end
        for (int j = 0; j < 20; j++) begin
            set_in(OP_HLT, 1'($urandom), 1'b0);
            e0 = exp_out(m_ph[0], m_hl[0], opcode, is_zero);
            n_vec++;
            if (ph1 !== 3'd4 || o1 !== 9'h001) begin
                n_err++;
                $display("FAIL halt_hold: cyc=%0d phase=%0d out=%b required phase=4 out=000000001", j, ph1, o1);
            end
            n_vec++;
            if (ph0 !== 3'(m_ph[0]) || o0 !== e0 || (j == 0 && (ph0 !== 3'd5 || o0[0] !== 1'b0))) begin
                n_err++;
                $display("FAIL halt_pulse_mode: cyc=%0d phase=%0d out=%b required phase=%0d out=%b", j, ph0, o0, m_ph[0], e0);
            end
            tick();
        end
        set_in(OP_HLT, 1'b0, 1'b1);
        n_vec++;
        if (ph1 !== 3'd4 || o1 !== 9'h001) begin
            n_err++;
            $display("FAIL halt_cont_cycle: phase=%0d out=%b", ph1, o1);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(OP_HLT, 1'($urandom), 1'b0);
            n_vec++;
            if (ph1 !== 3'((5 + i) % 8) || o1 !== ((i < 3) ? 9'h000 : 9'h100)) begin
                n_err++;
                $display("FAIL halt_resume: cyc=%0d phase=%0d out=%b required phase=%0d", i, ph1, o1, (5 + i) % 8);
            end
            tick();
        end
        // cont held high: resumes once per halt, re-halts at the next phase 4
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_in(OP_HLT, 1'($urandom), 1'b1);
            n_vec++;
            if (ph1 !== 3'(m_ph[1]) || o1 !== exp_out(m_ph[1], m_hl[1], opcode, is_zero) ||
                ((i == 5 || i == 14) && o1 !== 9'h001) || (i == 6 && ph1 !== 3'd5)) begin
                n_err++;
                $display("FAIL halt_cont_held: cyc=%0d phase=%0d out=%b required phase=%0d out=%b", i, ph1, o1,
                         m_ph[1], exp_out(m_ph[1], m_hl[1], opcode, is_zero));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(OP_ADD, 1'b0, 1'b0);
            tick();
        end
        set_in(OP_STO, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (ph1 !== 3'd0 || o1 !== 9'h100) begin
            n_err++;
            $display("FAIL async_rst_ph6: phase=%0d out=%b required phase=0 out=100000000", ph1, o1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_in(OP_HLT, 1'b0, 1'b0);
            n_vec++;
            if (ph1 !== 3'(m_ph[1]) || (i < 2 && ph1 !== 3'(i))) begin
                n_err++;
                $display("FAIL async_restart: cyc=%0d phase=%0d required %0d", i, ph1, m_ph[1]);
            end
            tick();
        end
        set_in(OP_HLT, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (ph1 !== 3'd0 || o1 !== 9'h100) begin
            n_err++;
            $display("FAIL async_rst_halted: phase=%0d out=%b required phase=0 out=100000000", ph1, o1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(OP_ADD, 1'b0, 1'b0);
            n_vec++;
            if (ph1 !== 3'(i) || o1 !== exp_out(i, 1'b0, opcode, is_zero)) begin
                n_err++;
                $display("FAIL async_halted_restart: cyc=%0d phase=%0d out=%b required phase=%0d", i, ph1, o1, i);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [8:0] e1, e0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 5) == 0));
            e1 = exp_out(m_ph[1], m_hl[1], opcode, is_zero);
            e0 = exp_out(m_ph[0], m_hl[0], opcode, is_zero);
            n_vec++;
            if (ph1 !== 3'(m_ph[1]) || o1 !== e1) begin
                n_err++;
                $display("FAIL rand_sticky: cyc=%0d op=%0d phase=%0d out=%b required phase=%0d out=%b",
                         i, opcode, ph1, o1, m_ph[1], e1);
            end
            n_vec++;
            if (ph0 !== 3'(m_ph[0]) || o0 !== e0) begin
                n_err++;
                $display("FAIL rand_pulse: cyc=%0d op=%0d phase=%0d out=%b required phase=%0d out=%b",
                         i, opcode, ph0, o0, m_ph[0], e0);
            end
            n_vec++;
            if ((o1[5] && o1[4]) || (o1[1] && !o1[3]) || (o0[5] && o0[4]) || (o0[1] && !o0[3])) begin
                n_err++;
                $display("FAIL rand_exclusive: cyc=%0d out=%b pulse_out=%b", i, o1, o0);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_skz();
        test_sto();
        test_jmp();
        test_halt();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
